// File: rtl/mario_keys_if.sv
// mario_keys_if: PS/2 pins, game clear and decoded key outputs of the
// mario_keys front end. The keyboard/game side uses the master modport,
// the decoder uses the slave modport.
interface mario_keys_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       clr;
    logic [4:0] keydown;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, clr,
        input  keydown, code, code_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, clr,
        output keydown, code, code_valid, frame_err
    );
endinterface

// File: rtl/mario_keys.sv
// mario_keys: PS/2 scan-code set 2 receiver for the Mario core.
// Synchronizes and glitch-filters the PS/2 lines, deframes 11-bit frames
// with odd parity and a frame timeout, tracks E0/F0 prefixes and keeps a
// level-held keydown vector: [0] up, [1] down, [2] left, [3] right, [4] jump.
// Optional feature: define MARIO_KEYS_WASD_EN to also decode W/S/A/D
// (1D/1B/1C/23) onto the up/down/left/right bits.
module mario_keys #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic        clk,
    input  logic        rst,
    mario_keys_if.slave kb
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_csync;
    logic [1:0]    r_dsync;
    logic          r_filt;
    logic [FW-1:0] r_fcnt;
    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_tmo;
    logic [4:0]    r_keydown;
    logic [7:0]    r_code;
    logic          r_cv;
    logic          r_fe;
    logic          r_e0;
    logic          r_f0;

    logic          w_c;
    logic          w_d;
    logic          w_flip;
    logic          w_edge;
    logic          w_accept;
    logic          w_ferr;
    logic          w_tmo_hit;
    logic [4:0]    w_keymask;

    // One-hot keydown bit for a completed byte, given the extension state;
    // a code seen with the wrong extension maps to nothing.
    function automatic logic [4:0] key_mask(input logic ext, input logic [7:0] b);
        logic [4:0] m;
        m = '0;
        if (ext) begin
            case (b)
                8'h75:   m[0] = 1'b1;
                8'h72:   m[1] = 1'b1;
                8'h6B:   m[2] = 1'b1;
                8'h74:   m[3] = 1'b1;
                default: m = '0;
            endcase
        end else begin
            case (b)
                8'h29:   m[4] = 1'b1;
`ifdef MARIO_KEYS_WASD_EN
                8'h1D:   m[0] = 1'b1;
                8'h1B:   m[1] = 1'b1;
                8'h1C:   m[2] = 1'b1;
                8'h23:   m[3] = 1'b1;
`endif
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    assign w_c       = r_csync[1];
    assign w_d       = r_dsync[1];
    assign w_flip    = (w_c != r_filt) && (r_fcnt == FLT_MAX);
    assign w_edge    = w_flip && r_filt;
    assign w_keymask = key_mask(r_e0, r_shift);

    // Two-flop synchronizers; idle level of both PS/2 lines is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csync <= 2'b11;
            r_dsync <= 2'b11;
        end else begin
            r_csync <= {r_csync[0], kb.ps2_clk};
            r_dsync <= {r_dsync[0], kb.ps2_data};
        end
    end

    // Glitch filter: the clock only changes after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
        end else if (w_c == r_filt) begin
            r_fcnt <= '0;
        end else if (w_flip) begin
            r_filt <= w_c;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Frame FSM next state plus accept/error strobes; clr overrides everything.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_ferr    = 1'b0;
        w_tmo_hit = (r_state != S_IDLE) && !w_edge && (r_tmo == TMO_MAX);
        case (r_state)
            S_IDLE:   if (w_edge && !w_d) w_next = S_DATA;
            S_DATA:   if (w_edge && r_bitcnt == 3'd7) w_next = S_PARITY;
            S_PARITY: if (w_edge) w_next = S_STOP;
            S_STOP: begin
                if (w_edge) begin
                    w_next = S_IDLE;
                    if (w_d && r_par_ok) w_accept = 1'b1;
                    else                 w_ferr   = 1'b1;
                end
            end
            default:  w_next = S_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_next = S_IDLE;
            w_ferr = 1'b1;
        end
        if (kb.clr) begin
            w_next   = S_IDLE;
            w_accept = 1'b0;
            w_ferr   = 1'b0;
        end
    end

    // Bit counter, inter-edge timeout counter, LSB-first shifter and parity check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt <= '0;
            r_tmo    <= '0;
        end else begin
            if (r_state == S_IDLE || w_edge || kb.clr) r_tmo <= '0;
            else                                       r_tmo <= r_tmo + 1'b1;
            if (r_state == S_IDLE)                r_bitcnt <= '0;
            else if (r_state == S_DATA && w_edge) r_bitcnt <= r_bitcnt + 1'b1;
        end
        if (r_state == S_DATA && w_edge)   r_shift  <= {w_d, r_shift[7:1]};
        if (r_state == S_PARITY && w_edge) r_par_ok <= ^{r_shift, w_d};
    end

    // Byte decoder: prefix flags, key press/release tracking and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keydown <= '0;
            r_code    <= '0;
            r_cv      <= 1'b0;
            r_fe      <= 1'b0;
            r_e0      <= 1'b0;
            r_f0      <= 1'b0;
        end else begin
            r_cv <= 1'b0;
            r_fe <= 1'b0;
            if (kb.clr) begin
                r_keydown <= '0;
                r_e0      <= 1'b0;
                r_f0      <= 1'b0;
            end else if (w_ferr) begin
                r_fe <= 1'b1;
                r_e0 <= 1'b0;
                r_f0 <= 1'b0;
            end else if (w_accept) begin
                r_cv   <= 1'b1;
                r_code <= r_shift;
                if (r_shift == 8'hE0) begin
                    r_e0 <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_f0 <= 1'b1;
                end else begin
                    if (r_f0) r_keydown <= r_keydown & ~w_keymask;
                    else      r_keydown <= r_keydown | w_keymask;
                    r_e0 <= 1'b0;
                    r_f0 <= 1'b0;
                end
            end
        end
    end

    assign kb.keydown    = r_keydown;
    assign kb.code       = r_code;
    assign kb.code_valid = r_cv;
    assign kb.frame_err  = r_fe;
endmodule

// File: tb/tb_mario_keys.sv
// tb_mario_keys: directed PS/2 frames against mario_keys with a
// key-table model of make/break/prefix handling and a per-cycle monitor.
`timescale 1ns/1ps
module tb_mario_keys;
    localparam int FL = 2;
    localparam int TO = 200;
    localparam int HP = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mario_keys_if kb_if();

    mario_keys #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .kb  (kb_if)
    );

    int   total = 0;
    int   bad   = 0;
    int   cv_cnt = 0;
    int   fe_cnt = 0;
    bit   chk_en = 0;
    bit   prev_cv = 0;
    bit   prev_fe = 0;
    logic [4:0] m_kd;
    logic [7:0] m_code;
    bit   m_e0, m_f0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Key table: {extended, code} -> keydown bit index, -1 if not a game key.
    function automatic int key_index(input bit ext, input logic [7:0] c);
        logic [8:0] k;
        k = {ext, c};
        if (k == 9'h175) return 0;
        if (k == 9'h172) return 1;
        if (k == 9'h16B) return 2;
        if (k == 9'h174) return 3;
        if (k == 9'h029) return 4;
`ifdef MARIO_KEYS_WASD_EN
        if (k == 9'h01D) return 0;
        if (k == 9'h01B) return 1;
        if (k == 9'h01C) return 2;
        if (k == 9'h023) return 3;
`endif
        return -1;
    endfunction

    task automatic model_accept(input logic [7:0] b);
        int idx;
        m_code = b;
        if (b == 8'hE0) m_e0 = 1;
        else if (b == 8'hF0) m_f0 = 1;
        else begin
            idx = key_index(m_e0, b);
            if (idx >= 0) m_kd[idx] = !m_f0;
            m_e0 = 0;
            m_f0 = 0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pulse counting and width, and per-cycle output comparison while idle.
    always @(negedge clk) begin
        if (rst) begin
            prev_cv <= 0;
            prev_fe <= 0;
        end else begin
            if (kb_if.code_valid === 1'b1) begin
                cv_cnt <= cv_cnt + 1;
                check("code_valid_width", 32'(prev_cv), 32'd0);
            end
            if (kb_if.frame_err === 1'b1) begin
                fe_cnt <= fe_cnt + 1;
                check("frame_err_width", 32'(prev_fe), 32'd0);
            end
            prev_cv <= kb_if.code_valid;
            prev_fe <= kb_if.frame_err;
            if (chk_en) begin
                check("keydown", 32'(kb_if.keydown), 32'(m_kd));
                check("code", 32'(kb_if.code), 32'(m_code));
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit badpar, input bit clr_stop);
        logic [10:0] bits;
        int cv0, fe0;
        chk_en = 0;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        bits = {1'b1, (~^b) ^ badpar, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            kb_if.ps2_data = bits[i];
            cyc(HP/2);
            kb_if.ps2_clk = 1'b0;
            if (clr_stop && i == 10) begin
                // clr lands in the cycle the filtered stop-bit edge is detected
                cyc(FL + 1);
                kb_if.clr = 1'b1;
                cyc(1);
                kb_if.clr = 1'b0;
                cyc(HP - FL - 2);
            end else begin
                cyc(HP);
            end
            kb_if.ps2_clk = 1'b1;
            cyc(HP/2);
        end
        cyc(5);
        if (clr_stop) begin
            m_kd = '0;
            m_e0 = 0;
            m_f0 = 0;
            check("clr_stop_cv", 32'(cv_cnt - cv0), 32'd0);
            check("clr_stop_fe", 32'(fe_cnt - fe0), 32'd0);
        end else if (badpar) begin
            m_e0 = 0;
            m_f0 = 0;
            check("badpar_cv", 32'(cv_cnt - cv0), 32'd0);
            check("badpar_fe", 32'(fe_cnt - fe0), 32'd1);
        end else begin
            model_accept(b);
            check("frame_cv", 32'(cv_cnt - cv0), 32'd1);
            check("frame_fe", 32'(fe_cnt - fe0), 32'd0);
        end
        chk_en = 1;
    endtask

    // Start bit plus nbits data bits, then either a reset or a long idle.
    task automatic send_partial(input logic [7:0] b, input int nbits, input bit do_rst);
        int cv0, fe0;
        chk_en = 0;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i <= nbits; i++) begin
            kb_if.ps2_data = (i == 0) ? 1'b0 : b[i-1];
            cyc(HP/2);
            kb_if.ps2_clk = 1'b0;
            cyc(HP);
            kb_if.ps2_clk = 1'b1;
            cyc(HP/2);
        end
        kb_if.ps2_data = 1'b1;
        if (do_rst) begin
            rst = 1'b1;
            cyc(3);
            rst = 1'b0;
            m_kd = '0;
            m_code = '0;
            m_e0 = 0;
            m_f0 = 0;
            cyc(1);
            check("rst_keydown", 32'(kb_if.keydown), 32'd0);
            check("rst_code", 32'(kb_if.code), 32'd0);
            check("rst_code_valid", 32'(kb_if.code_valid), 32'd0);
            check("rst_frame_err", 32'(kb_if.frame_err), 32'd0);
            cv0 = cv_cnt;
            fe0 = fe_cnt;
        end else begin
            m_e0 = 0;
            m_f0 = 0;
        end
        cyc(TO + 100);
        check("partial_cv", 32'(cv_cnt - cv0), 32'd0);
        check("partial_fe", 32'(fe_cnt - fe0), do_rst ? 32'd0 : 32'd1);
        chk_en = 1;
    endtask

    task automatic pulse_clr();
        chk_en = 0;
        kb_if.clr = 1'b1;
        cyc(1);
        kb_if.clr = 1'b0;
        cyc(2);
        m_kd = '0;
        m_e0 = 0;
        m_f0 = 0;
        chk_en = 1;
    endtask

    initial begin
        int c0;
        kb_if.ps2_clk  = 1'b1;
        kb_if.ps2_data = 1'b1;
        kb_if.clr      = 1'b0;
        m_kd = '0;
        m_code = '0;
        m_e0 = 0;
        m_f0 = 0;
        rst = 1'b1;
        cyc(5);
        rst = 1'b0;
        cyc(1);
        check("reset_keydown", 32'(kb_if.keydown), 32'd0);
        check("reset_code", 32'(kb_if.code), 32'd0);
        check("reset_code_valid", 32'(kb_if.code_valid), 32'd0);
        check("reset_frame_err", 32'(kb_if.frame_err), 32'd0);
        chk_en = 1;

        // Right arrow press and release
        c0 = cv_cnt;
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);
        check("e0_74_keydown", 32'(kb_if.keydown), 32'h08);
        check("e0_74_code", 32'(kb_if.code), 32'h74);
        check("e0_74_cv_pulses", 32'(cv_cnt - c0), 32'd2);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h74, 0, 0);
        check("e0_f0_74_keydown", 32'(kb_if.keydown), 32'h00);

        // Jump, then left, then release jump
        send_frame(8'h29, 0, 0);
        check("jump_keydown", 32'(kb_if.keydown), 32'h10);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h6B, 0, 0);
        check("jump_left_keydown", 32'(kb_if.keydown), 32'h14);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h29, 0, 0);
        check("left_only_keydown", 32'(kb_if.keydown), 32'h04);

        // Bad parity leaves keys alone; next good frame decodes
        send_frame(8'h74, 1, 0);
        check("badpar_keydown", 32'(kb_if.keydown), 32'h04);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        check("up_after_err", 32'(kb_if.keydown[0]), 32'd1);

        // Timeout after a truncated frame, then normal decode
        send_partial(8'h29, 4, 0);
        send_frame(8'h29, 0, 0);
        check("jump_after_timeout", 32'(kb_if.keydown), 32'h15);

        // clr on the completing stop bit
        pulse_clr();
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        check("pre_clr_keydown", 32'(kb_if.keydown), 32'h09);
        send_frame(8'h29, 0, 1);
        check("clr_stop_keydown", 32'(kb_if.keydown), 32'h00);

        // clr also drops a pending E0 prefix
        send_frame(8'hE0, 0, 0);
        pulse_clr();
        send_frame(8'h74, 0, 0);
        check("clr_flags_keydown", 32'(kb_if.keydown), 32'h00);

        // Wrong extension state is ignored
        send_frame(8'hE0, 0, 0);
        send_frame(8'h29, 0, 0);
        check("wrong_ext_keydown", 32'(kb_if.keydown), 32'h00);

        // Opposite directions held together
        send_frame(8'hE0, 0, 0);
        send_frame(8'h6B, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);
        check("left_right_keydown", 32'(kb_if.keydown), 32'h0C);
        send_frame(8'h29, 0, 0);

        // Reset mid-frame
        send_partial(8'h75, 3, 1);

        // W/A/S/D alias
        send_frame(8'h1C, 0, 0);
        check("code_1c", 32'(kb_if.code), 32'h1C);
`ifdef MARIO_KEYS_WASD_EN
        check("wasd_1c_keydown", 32'(kb_if.keydown), 32'h04);
`else
        check("wasd_1c_keydown", 32'(kb_if.keydown), 32'h00);
`endif
        cyc(10);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mario_keys.md
# mario_keys

PS/2 keyboard front end for the Mario game core. It receives scan-code set 2 frames from the keyboard's `ps2_clk`/`ps2_data` lines, tracks make/break codes, and presents a level-held 5-bit `keydown` vector. That vector drives the `keydown` input of `mario` directly, so a bit stays high for exactly as long as its key is physically held.

## Interface
- `FILTER_LEN`, 8: number of consecutive identical synchronized `ps2_clk` samples required before the filtered clock changes.
- `TIMEOUT`, 10000: maximum number of `clk` cycles allowed between falling edges inside a frame (200 us at 50 MHz).
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous clear; releases all keys and flushes decoder state (driven by game `over`).
- `ps2_clk`  in  1  asynchronous PS/2 clock line.
- `ps2_data`  in  1  asynchronous PS/2 data line.
- `keydown`  out  5  held keys: [0] up, [1] down, [2] left, [3] right, [4] jump.
- `code`  out  8  last correctly received byte.
- `code_valid`  out  1  one-cycle pulse; `code` is new.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Input conditioning: both lines pass through 2-flop synchronizers. The synchronized `ps2_clk` feeds the FILTER_LEN glitch filter; the filtered clock resets to 1.
- A falling edge is a 1->0 transition of the filtered clock. `ps2_data` (synchronized) is sampled in the edge cycle.
- Frame FSM states and transitions:
  - IDLE: edge with data=0 -> DATA with bitcnt=0; edge with data=1 is ignored.
  - DATA: shift LSB-first; after the 8th bit -> PARITY.
  - PARITY: compute odd parity over data+parity bit -> STOP.
  - STOP: data=1 and parity good -> byte accepted; otherwise `frame_err`. Always -> IDLE.
- Timeout: in any non-IDLE state, the cycle counter resets on each edge. Reaching TIMEOUT -> IDLE with a `frame_err` pulse.
- Any error clears the `e0_seen` and `f0_seen` flags. `keydown` is unchanged on error.
- Byte handling (accepted bytes only; `code_valid` pulses for every accepted byte, including E0 and F0):
  - E0 sets `e0_seen`; F0 sets `f0_seen`.
  - Any other byte: look up the key, then write `keydown[k]` = !`f0_seen` if it maps, then clear both flags.
- Key map, extended (E0-prefixed): 75 up, 72 down, 6B left, 74 right.
- Key map, plain: 29 (space) jump.
- Unmapped codes, and mapped codes with the wrong extension state, do not change `keydown`.
- Priority: `rst` > `clr` > decode. `clr` zeroes `keydown` and both flags, returns the FSM to IDLE, and suppresses any byte completing in that cycle, including its `code_valid`.

## Timing
- Reset values: `keydown`=0, `code`=0x00, `code_valid`=0, `frame_err`=0, FSM=IDLE, flags=0, filtered clock=1.
- Edge-detect latency from the pin: 2 synchronizer cycles + FILTER_LEN cycles.
- Let cycle N be the cycle in which the stop-bit edge is detected. `code`, `code_valid` and `keydown` all update at the register edge ending cycle N, so they are visible in cycle N+1.
- `frame_err` is visible in the cycle after the failing edge or after the timeout count is reached.
- `rst` or `clr` asserted mid-frame discards the partial byte. Decoding restarts cleanly from the next start bit.
- Overlapping keys are independent; opposite directions may be high simultaneously. Arbitration belongs to `mario`.

## Configuration
- `MARIO_KEYS_WASD_EN` defined: additionally decode the plain codes 1D->up, 1B->down, 1C->left, 23->right. These OR into the same `keydown` bits.
- Because the bits are shared, a break of either alias clears the bit.
- `MARIO_KEYS_WASD_EN` undefined: only the arrow keys and space are decoded; 1D/1B/1C/23 are ignored.

## Test plan
- Send E0 74 -> `keydown`=5'b01000; `code_valid` pulses twice; `code`=0x74. Then send E0 F0 74 -> `keydown`=0.
- Send 29 -> `keydown`=5'b10000. Then send E0 6B -> 5'b10100. Then send F0 29 -> 5'b00100.
- Send 74 with bad parity -> one `frame_err` pulse, `keydown` unchanged. A following good E0 75 -> `keydown[0]`=1.
- Send a start bit plus 4 data bits, then idle >TIMEOUT -> `frame_err` pulse, FSM back in IDLE. A following 29 decodes normally.
- With `keydown`=5'b01001, assert `clr` for one cycle while a stop bit completes -> `keydown`=0, no `code_valid` in that cycle. Assert `rst` mid-frame -> all outputs 0.
- Send 1C:
  - `MARIO_KEYS_WASD_EN` defined -> `keydown`=5'b00100.
  - `MARIO_KEYS_WASD_EN` undefined -> `keydown`=0, `code_valid` pulse with `code`=0x1C.
- Bench setup: use FILTER_LEN=2 and TIMEOUT=200, with a PS/2 half-period of 20 `clk` cycles.
